// File: rtl/program_flow_mt.sv
// Multi-context program-flow controller: N_CTX contexts served round-robin, each
// with its own PC, jump counter and return-address stack.
module program_flow_mt #(
    parameter  int ADDR_W    = 8,
    parameter  int N_CTX     = 2,
    parameter  int RA_DEPTH  = 4,
    parameter  int JC_W      = 3,
    parameter  int STACK_LEN = 6,
    localparam int CTX_W     = (N_CTX > 1) ? $clog2(N_CTX) : 1,
    localparam int SP_W      = $clog2(RA_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic [2:0]           op,
    input  logic                 tgt_src,
    input  logic                 mux_offs,
    input  logic                 en_addr_hi,
    input  logic                 en_addr_lo,
    input  logic [JC_W-2:0]      n,
    input  logic [ADDR_W-1:0]    in_data,
    input  logic [STACK_LEN-1:0] in_stack,
    input  logic [ADDR_W-1:0]    cfg_state_offs,
    input  logic [ADDR_W-1:0]    cfg_trans_offs,
    input  logic [N_CTX-1:0]     ctx_flush,
    input  logic [CTX_W-1:0]     db_ctx,
    output logic [ADDR_W-1:0]    out_mem,
    output logic [CTX_W-1:0]     out_ctx,
    output logic [N_CTX-1:0]     err,
    output logic [ADDR_W-1:0]    db_pc,
    output logic [JC_W-1:0]      db_jc,
    output logic [SP_W-1:0]      db_sp,
    output logic [ADDR_W-1:0]    db_ra_top
);

    localparam int RA_W = (RA_DEPTH > 1) ? $clog2(RA_DEPTH) : 1;

    typedef enum logic [2:0] {
        OP_HOLD  = 3'd0,
        OP_NEXT  = 3'd1,
        OP_JMP   = 3'd2,
        OP_CALL  = 3'd3,
        OP_CALLN = 3'd4,
        OP_RET   = 3'd5,
        OP_RSV6  = 3'd6,
        OP_RSV7  = 3'd7
    } op_e;

    logic [CTX_W-1:0]  cur_ctx;
    logic [ADDR_W-1:0] pc [N_CTX];
    logic [JC_W-1:0]   jc [N_CTX];
    logic [SP_W-1:0]   sp [N_CTX];
    logic [ADDR_W-1:0] ra [N_CTX][RA_DEPTH];

    op_e               cur_op;
    logic [ADDR_W-1:0] cur_pc;
    logic [JC_W-1:0]   cur_jc;
    logic [SP_W-1:0]   cur_sp;
    logic [ADDR_W-1:0] operand_mask;
    logic [ADDR_W-1:0] operand;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc_inc;
    logic [RA_W-1:0]   push_idx;
    logic [RA_W-1:0]   pop_idx;
    logic              stack_full;
    logic              stack_empty;
    logic              auto_ret;

    logic [ADDR_W-1:0] nxt_pc;
    logic [JC_W-1:0]   nxt_jc;
    logic [SP_W-1:0]   nxt_sp;
    logic              set_err;
    logic              ra_we;
    logic              do_push;
    logic              do_pop;

    assign cur_op       = op_e'(op);
    assign cur_pc       = pc[cur_ctx];
    assign cur_jc       = jc[cur_ctx];
    assign cur_sp       = sp[cur_ctx];
    assign operand_mask = {{(ADDR_W-4){en_addr_hi}}, {4{en_addr_lo}}};
    assign operand      = tgt_src ? ADDR_W'(in_stack) : (in_data & operand_mask);
    assign target       = (mux_offs ? cfg_state_offs : cfg_trans_offs) + operand;
    assign pc_inc       = cur_pc + ADDR_W'(1);
    assign push_idx     = RA_W'(cur_sp);
    assign pop_idx      = RA_W'(cur_sp - SP_W'(1));
    assign stack_full   = (cur_sp == SP_W'(RA_DEPTH));
    assign stack_empty  = (cur_sp == '0);
    // A counted call expires on the slot where JC steps from 1 to 0.
    assign auto_ret     = (cur_op != OP_CALLN) && (cur_jc == JC_W'(1));

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        nxt_pc  = cur_pc;
        nxt_jc  = cur_jc;
        nxt_sp  = cur_sp;
        set_err = 1'b0;
        ra_we   = 1'b0;
        do_push = 1'b0;
        do_pop  = 1'b0;

        if (cur_op == OP_CALLN) begin
            nxt_jc = JC_W'(n) + JC_W'(2);
        end else if (cur_jc != '0) begin
            nxt_jc = cur_jc - JC_W'(1);
        end

        if (auto_ret) begin
            do_pop = 1'b1;
        end else begin
            case (cur_op)
                OP_NEXT:           nxt_pc = pc_inc;
                OP_JMP:            nxt_pc = target;
                OP_CALL, OP_CALLN: begin
                    nxt_pc  = target;
                    do_push = 1'b1;
                end
                OP_RET:            do_pop = 1'b1;
                default:           ;
            endcase
        end

        if (do_push) begin
            if (stack_full) begin
                set_err = 1'b1;
            end else begin
                ra_we  = 1'b1;
                nxt_sp = cur_sp + SP_W'(1);
            end
        end

        // Underflow leaves PC where it was; only the sticky flag records it.
        if (do_pop) begin
            if (stack_empty) begin
                set_err = 1'b1;
            end else begin
                nxt_pc = ra[cur_ctx][pop_idx];
                nxt_sp = cur_sp - SP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_ctx <= '0;
            err     <= '0;
            // NOTE: the RA storage is reset along with the pointers so db_ra_top and pops never expose stale data after reset.
            for (int i = 0; i < N_CTX; i++) begin
                pc[i] <= '0;
                jc[i] <= '0;
                sp[i] <= '0;
                for (int j = 0; j < RA_DEPTH; j++) begin
                    ra[i][j] <= '0;
                end
            end
        end else begin
            // NOTE: all state uses non-blocking assignments; the flush loop below is the later assignment, so it wins on the same context.
            if (!stall) begin
                cur_ctx     <= cur_ctx + CTX_W'(1);
                pc[cur_ctx] <= nxt_pc;
                jc[cur_ctx] <= nxt_jc;
                sp[cur_ctx] <= nxt_sp;
                if (set_err) begin
                    err[cur_ctx] <= 1'b1;
                end
                if (ra_we) begin
                    ra[cur_ctx][push_idx] <= pc_inc;
                end
            end
            for (int i = 0; i < N_CTX; i++) begin
                if (ctx_flush[i]) begin
                    pc[i]  <= '0;
                    jc[i]  <= '0;
                    sp[i]  <= '0;
                    err[i] <= 1'b0;
                end
            end
        end
    end

    logic [SP_W-1:0] db_sp_q;

    assign db_sp_q   = sp[db_ctx];
    assign out_mem   = cur_pc;
    assign out_ctx   = cur_ctx;
    assign db_pc     = pc[db_ctx];
    assign db_jc     = jc[db_ctx];
    assign db_sp     = db_sp_q;
    assign db_ra_top = (db_sp_q == '0) ? '0 : ra[db_ctx][RA_W'(db_sp_q - SP_W'(1))];

endmodule
